// File: rtl/scv_hmi_matrix_if.sv
// CPU-side port bundle for scv_hmi_matrix.
//   PA_I      : CPU port A row select, active-low (CPU -> matrix)
//   PB_O      : CPU port B column data, active-low, 1 = released (matrix -> CPU)
//   PAUSE_IRQ : latched pause request to CPU INT0 (matrix -> CPU)
//   PAUSE_ACK : one-CLK pulse that clears PAUSE_IRQ (CPU -> matrix)
// master = CPU side, slave = matrix side.
interface scv_hmi_matrix_if;
    logic [7:0] PA_I;
    logic [7:0] PB_O;
    logic       PAUSE_IRQ;
    logic       PAUSE_ACK;

    modport master (output PA_I, output PAUSE_ACK, input PB_O, input PAUSE_IRQ);
    modport slave  (input PA_I, input PAUSE_ACK, output PB_O, output PAUSE_IRQ);
endinterface

// File: rtl/scv_hmi_matrix.sv
// SCV HMI key matrix.
// Synchronises and debounces the raw host inputs, presents them as the active-low key
// matrix the CPU scans (row select on PA_I, column data on PB_O), and latches a pause
// interrupt request on the debounced rising edge of PAUSE.
//
// Ports:
//   CLK      : system clock, rising edge
//   RES      : synchronous reset, active-high
//   CE       : one-CLK tick enable for debounce and autofire
//   HMI      : raw inputs, 1 = pressed. Bit map:
//              [0] c1.l [1] c1.u [2] c1.d [3] c1.r [4] c1.t1 [5] c1.t2
//              [6] c2.l [7] c2.u [8] c2.d [9] c2.r [10] c2.t1 [11] c2.t2
//              [21:12] num[9:0]  [22] cl  [23] en  [24] pause
//   AUTOFIRE : [0] c1, [1] c2 autofire select (only with SCV_HMI_AUTOFIRE_EN)
//   cpu      : PA_I / PB_O / PAUSE_IRQ / PAUSE_ACK bundle (slave modport)
//
// Build option: define SCV_HMI_AUTOFIRE_EN to add the AUTOFIRE port and t1 autofire gating.
module scv_hmi_matrix #(
    parameter int unsigned DB_TICKS = 4,
    parameter int unsigned AF_HALF  = 8
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        CE,
    input  logic [24:0] HMI,
`ifdef SCV_HMI_AUTOFIRE_EN
    input  logic [1:0]  AUTOFIRE,
`endif
    scv_hmi_matrix_if.slave cpu
);

    if (DB_TICKS < 1 || DB_TICKS > 15 || AF_HALF < 1 || AF_HALF > 255) begin : g_bad_param
        $error("scv_hmi_matrix: DB_TICKS or AF_HALF out of range");
    end

    localparam logic [3:0] DB_MAX = 4'(DB_TICKS - 1);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_PEND = 1'b1;

    logic [24:0]      sync1_q, sync2_q;
    logic [24:0]      db_q, db_d;
    logic [24:0][3:0] cnt_q, cnt_d;
    logic             state_q, state_d;
    logic [7:0]       pb_q, pb_d;
    logic [1:0]       t1_eff;
    logic [24:0]      key;
    logic [3:0]       row [8];
    logic [3:0]       hit;

    // Debounce: a bit must disagree with its debounced value for DB_TICKS
    // consecutive CE ticks before it is accepted.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (CE) begin
            for (int i = 0; i < 25; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    cnt_d[i] = 4'd0;
                end else if (cnt_q[i] == DB_MAX) begin
                    db_d[i]  = sync2_q[i];
                    cnt_d[i] = 4'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

`ifdef SCV_HMI_AUTOFIRE_EN
    localparam logic [7:0] AF_MAX = 8'(AF_HALF - 1);

    logic [1:0]      phase_q, phase_d;
    logic [1:0][7:0] af_cnt_q, af_cnt_d;

    // Phase idles at 1 so a fresh press starts in the pressed half-period.
    always_comb begin
        phase_d  = phase_q;
        af_cnt_d = af_cnt_q;
        for (int c = 0; c < 2; c++) begin
            if (!(AUTOFIRE[c] && db_q[4 + 6 * c])) begin
                phase_d[c]  = 1'b1;
                af_cnt_d[c] = 8'd0;
            end else if (CE) begin
                if (af_cnt_q[c] == AF_MAX) begin
                    phase_d[c]  = ~phase_q[c];
                    af_cnt_d[c] = 8'd0;
                end else begin
                    af_cnt_d[c] = af_cnt_q[c] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            phase_q  <= 2'b00;
            af_cnt_q <= '0;
        end else begin
            phase_q  <= phase_d;
            af_cnt_q <= af_cnt_d;
        end
    end

    assign t1_eff = {db_q[10] & phase_q[1], db_q[4] & phase_q[0]};
`else
    assign t1_eff = {db_q[10], db_q[4]};
`endif

    // Matrix rows as active-high "pressed" nibbles mapped onto PB[3:0].
    always_comb begin
        key     = db_q;
        key[4]  = t1_eff[0];
        key[10] = t1_eff[1];
        row[0]  = {key[7], key[6], key[1], key[0]};
        row[1]  = {key[9], key[8], key[3], key[2]};
        row[2]  = {key[11], key[10], key[5], key[4]};
        row[3]  = key[15:12];
        row[4]  = key[19:16];
        row[5]  = key[23:20];
        row[6]  = 4'h0;
        row[7]  = 4'h0;
        hit     = 4'h0;
        for (int r = 0; r < 8; r++) begin
            if (!cpu.PA_I[r]) hit = hit | row[r];
        end
        pb_d = {4'hF, ~hit};
    end

    // Pause FSM; the rising edge is taken from the debounce next-state so the
    // request appears on the same edge that accepts the press. Set beats ack.
    always_comb begin
        state_d = state_q;
        if (db_d[24] && !db_q[24]) begin
            state_d = ST_PEND;
        end else if (state_q == ST_PEND && cpu.PAUSE_ACK) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            pb_q    <= 8'hFF;
        end else begin
            sync1_q <= HMI;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            pb_q    <= pb_d;
        end
    end

    assign cpu.PB_O      = pb_q;
    assign cpu.PAUSE_IRQ = (state_q == ST_PEND);

endmodule

// File: tb/tb_scv_hmi_matrix.sv
module tb_scv_hmi_matrix;

    logic        clk;
    logic        res;
    logic        ce;
    logic [24:0] hmi;
`ifdef SCV_HMI_AUTOFIRE_EN
    logic [1:0]  autofire;
`endif

    scv_hmi_matrix_if cpu_if ();

    scv_hmi_matrix #(
        .DB_TICKS (4),
        .AF_HALF  (8)
    ) dut (
        .CLK      (clk),
        .RES      (res),
        .CE       (ce),
        .HMI      (hmi),
`ifdef SCV_HMI_AUTOFIRE_EN
        .AUTOFIRE (autofire),
`endif
        .cpu      (cpu_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] got);
        exp_t e;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_underflow: got=%0h expected=<queued value>", got);
        end else begin
            e = sb_q.pop_front();
            check_eq(e.tag, got, e.exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait for PB_O to reach a value; an expired budget shows as a failed check.
    task automatic wait_pb(input string tag, input logic [7:0] exp, input int budget);
        int n = 0;
        sb_push(tag, {24'h0, exp});
        while (cpu_if.PB_O !== exp && n < budget) begin
            @(negedge clk);
            n++;
        end
        sb_check({24'h0, cpu_if.PB_O});
    endtask

    // Reference matrix: HMI bit index for each (row, PB column).
    function automatic logic [7:0] model_pb(input logic [7:0] pa, input logic [24:0] keys);
        int map [6][4] = '{'{0, 1, 6, 7}, '{2, 3, 8, 9}, '{4, 5, 10, 11},
                           '{12, 13, 14, 15}, '{16, 17, 18, 19}, '{20, 21, 22, 23}};
        logic [7:0] res_pb = 8'hFF;
        for (int r = 0; r < 6; r++) begin
            if (!pa[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (keys[map[r][c]]) res_pb[c] = 1'b0;
                end
            end
        end
        return res_pb;
    endfunction

    initial begin
        #200us;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [24:0] keys;
        logic [7:0]  pa;
        int          bad;

        res              = 1'b1;
        ce               = 1'b1;
        hmi              = '0;
        cpu_if.PA_I      = 8'h00;
        cpu_if.PAUSE_ACK = 1'b0;
`ifdef SCV_HMI_AUTOFIRE_EN
        autofire         = 2'b00;
`endif

        // Reset held 3 CLK with all rows selected.
        tick(3);
        sb_push("reset_pb", 32'hFF);
        sb_check({24'h0, cpu_if.PB_O});
        sb_push("reset_irq", 32'h0);
        sb_check({31'h0, cpu_if.PAUSE_IRQ});
        res         = 1'b0;
        cpu_if.PA_I = 8'hFE;
        tick(2);

        // c1.u press: exact latency 2 sync + 4 debounce ticks + 1 output register.
        hmi[1] = 1'b1;
        tick(6);
        sb_push("press_early", 32'hFF);
        sb_check({24'h0, cpu_if.PB_O});
        tick(1);
        sb_push("press_c1u", 32'hFD);
        sb_check({24'h0, cpu_if.PB_O});
        hmi[1] = 1'b0;
        wait_pb("release_c1u", 8'hFF, 12);

        // Two-tick glitch must never reach PB_O.
        hmi[1] = 1'b1;
        tick(2);
        hmi[1] = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (cpu_if.PB_O !== 8'hFF) bad++;
        end
        sb_push("glitch", 32'h0);
        sb_check(32'(bad));

        // Debounce frozen while CE is low.
        ce     = 1'b0;
        hmi[1] = 1'b1;
        tick(20);
        sb_push("ce_hold", 32'hFF);
        sb_check({24'h0, cpu_if.PB_O});
        ce = 1'b1;
        wait_pb("ce_resume", 8'hFD, 12);
        hmi = '0;
        wait_pb("ce_release", 8'hFF, 12);

        // num[5] + num[2]: rows 3 and 4, then row 4 alone, 1 CLK after each PA change.
        cpu_if.PA_I = 8'hFF;
        hmi[12 + 5] = 1'b1;
        hmi[12 + 2] = 1'b1;
        tick(10);
        cpu_if.PA_I = 8'hE7;
        sb_push("num_rows34", 32'hF9);
        tick(1);
        sb_check({24'h0, cpu_if.PB_O});
        cpu_if.PA_I = 8'hEF;
        sb_push("num_row4", 32'hFD);
        tick(1);
        sb_check({24'h0, cpu_if.PB_O});
        cpu_if.PA_I = 8'hFF;
        sb_push("no_row", 32'hFF);
        tick(1);
        sb_check({24'h0, cpu_if.PB_O});

        // Opposing directions pass through.
        hmi         = '0;
        hmi[0]      = 1'b1;
        hmi[3]      = 1'b1;
        cpu_if.PA_I = 8'hFC;
        wait_pb("opposing_lr", 8'hFC, 14);

        // Mixed key set against random row selects.
        keys = '0;
        keys[0]  = 1'b1;
        keys[2]  = 1'b1;
        keys[4]  = 1'b1;
        keys[7]  = 1'b1;
        keys[11] = 1'b1;
        keys[13] = 1'b1;
        keys[21] = 1'b1;
        keys[23] = 1'b1;
        hmi = keys;
        tick(10);
        for (int i = 0; i < 10; i++) begin
            pa = (i == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            cpu_if.PA_I = pa;
            sb_push("rand_rows", {24'h0, model_pb(pa, keys)});
            tick(1);
            sb_check({24'h0, cpu_if.PB_O});
        end
        hmi         = '0;
        cpu_if.PA_I = 8'hFF;
        tick(10);

        // Pause: single request while held, ack clears, no retrigger.
        hmi[24] = 1'b1;
        tick(5);
        sb_push("pause_early", 32'h0);
        sb_check({31'h0, cpu_if.PAUSE_IRQ});
        tick(1);
        sb_push("pause_set", 32'h1);
        sb_check({31'h0, cpu_if.PAUSE_IRQ});
        tick(5);
        sb_push("pause_hold", 32'h1);
        sb_check({31'h0, cpu_if.PAUSE_IRQ});
        cpu_if.PAUSE_ACK = 1'b1;
        tick(1);
        cpu_if.PAUSE_ACK = 1'b0;
        sb_push("pause_ack", 32'h0);
        sb_check({31'h0, cpu_if.PAUSE_IRQ});
        tick(10);
        sb_push("pause_no_retrig", 32'h0);
        sb_check({31'h0, cpu_if.PAUSE_IRQ});

        // Release, re-press with ack on the edge that accepts the press.
        hmi[24] = 1'b0;
        tick(10);
        hmi[24] = 1'b1;
        tick(5);
        sb_push("repress_early", 32'h0);
        sb_check({31'h0, cpu_if.PAUSE_IRQ});
        cpu_if.PAUSE_ACK = 1'b1;
        tick(1);
        cpu_if.PAUSE_ACK = 1'b0;
        sb_push("set_beats_ack", 32'h1);
        sb_check({31'h0, cpu_if.PAUSE_IRQ});

        // Reset mid-debounce with a pending request.
        hmi[24] = 1'b0;
        tick(10);
        sb_push("irq_latched", 32'h1);
        sb_check({31'h0, cpu_if.PAUSE_IRQ});
        cpu_if.PA_I = 8'hFB;
        hmi[11]     = 1'b1;
        tick(4);
        res = 1'b1;
        tick(1);
        res = 1'b0;
        sb_push("res_irq", 32'h0);
        sb_check({31'h0, cpu_if.PAUSE_IRQ});
        sb_push("res_pb", 32'hFF);
        sb_check({24'h0, cpu_if.PB_O});
        tick(6);
        sb_push("t2_full_early", 32'hFF);
        sb_check({24'h0, cpu_if.PB_O});
        tick(1);
        sb_push("t2_full", 32'hF7);
        sb_check({24'h0, cpu_if.PB_O});

`ifdef SCV_HMI_AUTOFIRE_EN
        // c1 autofire, c2 plain: PB[0] alternates every 8 ticks starting pressed.
        hmi = '0;
        tick(10);
        autofire    = 2'b01;
        hmi[4]      = 1'b1;
        hmi[10]     = 1'b1;
        cpu_if.PA_I = 8'hFB;
        bad = 0;
        while (cpu_if.PB_O[0] !== 1'b0 && bad < 12) begin
            tick(1);
            bad++;
        end
        sb_push("af_start", 32'h0);
        sb_check({31'h0, cpu_if.PB_O[0]});
        for (int k = 0; k < 32; k++) begin
            sb_push("af_c1t1", 32'((k / 8) % 2));
            sb_check({31'h0, cpu_if.PB_O[0]});
            sb_push("af_c2t1", 32'h0);
            sb_check({31'h0, cpu_if.PB_O[2]});
            tick(1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
